id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_id_ex_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, downstream hold and jump flush.
// A load-use hazard inserts a one-cycle bubble; ex_stall freezes the whole stage.
module id_ex_pipe #(
    parameter logic [15:0] STALL_CNT_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm_ext,
    input  logic        ctl_ex_regwr,
    input  logic        ctl_memread,
    input  logic [1:0]  ctl_asel,
    input  logic        ctl_bsel,
    input  logic [4:0]  ctl_aluop,
    input  logic        ctl_wdstsel,
    input  logic        ctl_mem_regwr,
    input  logic [1:0]  ctl_be,
    input  logic        ctl_dmwr,
    input  logic        ctl_wb_regwr,
    input  logic [1:0]  ctl_wcsel,
    input  logic        ctl_wdstregsel,
    input  logic        ctl_jmp,
    input  logic        ctl_jmpr,
    input  logic        ex_stall,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm_ext,
    output logic        ex_ex_regwr,
    output logic        ex_memread,
    output logic [1:0]  ex_asel,
    output logic        ex_bsel,
    output logic [4:0]  ex_aluop,
    output logic        ex_wdstsel,
    output logic        ex_mem_regwr,
    output logic [1:0]  ex_be,
    output logic        ex_dmwr,
    output logic        ex_wb_regwr,
    output logic [1:0]  ex_wcsel,
    output logic        ex_wdstregsel,
    output logic        ex_valid,
    output logic [4:0]  ex_dst,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        hazard_stall,
    output logic [15:0] stall_cnt
);

    typedef enum logic {RUN, HOLD} state_t;

    typedef struct packed {
        logic       ex_regwr;
        logic       memread;
        logic [1:0] asel;
        logic       bsel;
        logic [4:0] aluop;
        logic       wdstsel;
        logic       mem_regwr;
        logic [1:0] be;
        logic       dmwr;
        logic       wb_regwr;
        logic [1:0] wcsel;
        logic       wdstregsel;
    } ctl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  dst;
    } data_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t      state_q, state_d;
    ctl_t        ctl_q, ctl_d, ctl_in;
    data_t       data_q, data_d, data_in;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic [5:0]  opcode;
    logic [4:0]  rs_idx, rt_idx, dst_in;
    logic        rs_used, rt_used, load_use;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= STALL_CNT_MAX) ? v : v + 16'd1;
    endfunction

    assign opcode = id_instr[31:26];
    assign rs_idx = id_instr[25:21];
    assign rt_idx = id_instr[20:16];

    assign dst_in = ctl_wdstregsel ? 5'd31 :
                    ctl_wdstsel    ? id_instr[15:11] : id_instr[20:16];

    assign rs_used = id_valid && (opcode != OP_J) && (opcode != OP_JAL) && (opcode != OP_LUI);
    assign rt_used = id_valid && ((opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                                  (opcode == OP_SW) || (opcode == OP_SB) || (opcode == OP_SH));

    // Compared against whatever EX currently holds, including contents frozen by a hold.
    assign load_use = valid_q && ctl_q.memread && (data_q.dst != 5'd0) &&
                      ((rs_used && (data_q.dst == rs_idx)) || (rt_used && (data_q.dst == rt_idx)));

    assign ctl_in = '{
        ex_regwr:   ctl_ex_regwr,
        memread:    ctl_memread,
        asel:       ctl_asel,
        bsel:       ctl_bsel,
        aluop:      ctl_aluop,
        wdstsel:    ctl_wdstsel,
        mem_regwr:  ctl_mem_regwr,
        be:         ctl_be,
        dmwr:       ctl_dmwr,
        wb_regwr:   ctl_wb_regwr,
        wcsel:      ctl_wcsel,
        wdstregsel: ctl_wdstregsel
    };

    assign data_in = '{
        instr:   id_instr,
        pc:      id_pc,
        rs_data: id_rs_data,
        rt_data: id_rt_data,
        imm_ext: id_imm_ext,
        dst:     dst_in
    };

    always_comb begin
        state_d      = state_q;
        ctl_d        = ctl_q;
        data_d       = data_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        hazard_stall = 1'b0;

        case (state_q)
            RUN:     if (ex_stall)  state_d = HOLD;
            HOLD:    if (!ex_stall) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (!rst) begin
            if (ex_stall) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (load_use) begin
                // Data registers still load; nothing downstream looks at them while invalid.
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                hazard_stall = 1'b1;
                ctl_d        = '0;
                valid_d      = 1'b0;
                data_d       = data_in;
                cnt_d        = sat_inc(cnt_q);
            end else begin
                ifid_flush = id_valid && (ctl_jmp || ctl_jmpr);
                ctl_d      = ctl_in;
                valid_d    = id_valid;
                data_d     = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ctl_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_instr      = data_q.instr;
    assign ex_pc         = data_q.pc;
    assign ex_rs_data    = data_q.rs_data;
    assign ex_rt_data    = data_q.rt_data;
    assign ex_imm_ext    = data_q.imm_ext;
    assign ex_dst        = data_q.dst;
    assign ex_ex_regwr   = ctl_q.ex_regwr;
    assign ex_memread    = ctl_q.memread;
    assign ex_asel       = ctl_q.asel;
    assign ex_bsel       = ctl_q.bsel;
    assign ex_aluop      = ctl_q.aluop;
    assign ex_wdstsel    = ctl_q.wdstsel;
    assign ex_mem_regwr  = ctl_q.mem_regwr;
    assign ex_be         = ctl_q.be;
    assign ex_dmwr       = ctl_q.dmwr;
    assign ex_wb_regwr   = ctl_q.wb_regwr;
    assign ex_wcsel      = ctl_q.wcsel;
    assign ex_wdstregsel = ctl_q.wdstregsel;
    assign ex_valid      = valid_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed instruction-sequence table, randomized run against a
// behavioural model, and a bubble-counter saturation run (with a reduced ceiling).
module tb_id_ex_pipe;

    localparam logic [15:0] CNT_MAX = 16'd50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, ex_stall;
    logic [31:0] id_instr, id_pc, id_rs_data, id_rt_data, id_imm_ext;
    logic        ctl_ex_regwr, ctl_memread, ctl_bsel, ctl_wdstsel, ctl_mem_regwr;
    logic        ctl_dmwr, ctl_wb_regwr, ctl_wdstregsel, ctl_jmp, ctl_jmpr;
    logic [1:0]  ctl_asel, ctl_be, ctl_wcsel;
    logic [4:0]  ctl_aluop;

    logic [31:0] ex_instr, ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic        ex_ex_regwr, ex_memread, ex_bsel, ex_wdstsel, ex_mem_regwr;
    logic        ex_dmwr, ex_wb_regwr, ex_wdstregsel, ex_valid;
    logic [1:0]  ex_asel, ex_be, ex_wcsel;
    logic [4:0]  ex_aluop, ex_dst;
    logic        pc_write, ifid_write, ifid_flush, hazard_stall;
    logic [15:0] stall_cnt;

    id_ex_pipe #(.STALL_CNT_MAX(CNT_MAX)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
        .ctl_ex_regwr(ctl_ex_regwr), .ctl_memread(ctl_memread), .ctl_asel(ctl_asel),
        .ctl_bsel(ctl_bsel), .ctl_aluop(ctl_aluop), .ctl_wdstsel(ctl_wdstsel),
        .ctl_mem_regwr(ctl_mem_regwr), .ctl_be(ctl_be), .ctl_dmwr(ctl_dmwr),
        .ctl_wb_regwr(ctl_wb_regwr), .ctl_wcsel(ctl_wcsel), .ctl_wdstregsel(ctl_wdstregsel),
        .ctl_jmp(ctl_jmp), .ctl_jmpr(ctl_jmpr), .ex_stall(ex_stall),
        .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_ex_regwr(ex_ex_regwr), .ex_memread(ex_memread),
        .ex_asel(ex_asel), .ex_bsel(ex_bsel), .ex_aluop(ex_aluop), .ex_wdstsel(ex_wdstsel),
        .ex_mem_regwr(ex_mem_regwr), .ex_be(ex_be), .ex_dmwr(ex_dmwr),
        .ex_wb_regwr(ex_wb_regwr), .ex_wcsel(ex_wcsel), .ex_wdstregsel(ex_wdstregsel),
        .ex_valid(ex_valid), .ex_dst(ex_dst), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [18:0] dut_ctl, in_ctl;
    assign dut_ctl = {ex_ex_regwr, ex_memread, ex_asel, ex_bsel, ex_aluop, ex_wdstsel,
                      ex_mem_regwr, ex_be, ex_dmwr, ex_wb_regwr, ex_wcsel, ex_wdstregsel};
    assign in_ctl  = {ctl_ex_regwr, ctl_memread, ctl_asel, ctl_bsel, ctl_aluop, ctl_wdstsel,
                      ctl_mem_regwr, ctl_be, ctl_dmwr, ctl_wb_regwr, ctl_wcsel, ctl_wdstregsel};

    // Behavioural model: what EX holds, and how many bubbles have been inserted.
    bit          m_valid;
    logic [18:0] m_ctl;
    logic [4:0]  m_dst;
    logic [31:0] m_instr, m_pc, m_rs, m_rt, m_imm;
    int          m_cnt;

    function automatic bit reads_rs();
        return id_valid && !(id_instr[31:26] inside {6'h02, 6'h03, 6'h0f});
    endfunction
    function automatic bit reads_rt();
        return id_valid && (id_instr[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2b, 6'h28, 6'h29});
    endfunction
    function automatic bit model_load_use();
        bit ex_is_load = m_valid && m_ctl[17] && (m_dst != 5'd0);
        return ex_is_load && ((reads_rs() && m_dst == id_instr[25:21]) ||
                              (reads_rt() && m_dst == id_instr[20:16]));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_ctl <= '0; m_dst <= '0; m_cnt <= 0;
            m_instr <= '0; m_pc <= '0; m_rs <= '0; m_rt <= '0; m_imm <= '0;
        end else if (!ex_stall) begin
            if (model_load_use()) begin
                m_valid <= 1'b0;
                m_ctl   <= '0;
                m_cnt   <= (m_cnt < int'(CNT_MAX)) ? m_cnt + 1 : m_cnt;
            end else begin
                m_valid <= id_valid;
                m_ctl   <= in_ctl;
                m_dst   <= ctl_wdstregsel ? 5'd31 : (ctl_wdstsel ? id_instr[15:11] : id_instr[20:16]);
                m_instr <= id_instr; m_pc <= id_pc; m_rs <= id_rs_data;
                m_rt    <= id_rt_data; m_imm <= id_imm_ext;
            end
        end
    end

    task automatic model_check();
        bit lu  = model_load_use();
        bit run = !rst && !ex_stall;
        chk("pc_write", 32'(pc_write), 32'(rst || (!ex_stall && !lu)));
        chk("ifid_write", 32'(ifid_write), 32'(rst || (!ex_stall && !lu)));
        chk("hazard_stall", 32'(hazard_stall), 32'(run && lu));
        chk("ifid_flush", 32'(ifid_flush), 32'(run && !lu && id_valid && (ctl_jmp || ctl_jmpr)));
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_ctl", 32'(dut_ctl), 32'(m_ctl));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (m_valid) begin
            chk("ex_dst", 32'(ex_dst), 32'(m_dst));
            chk("ex_instr", ex_instr, m_instr);
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rs_data", ex_rs_data, m_rs);
            chk("ex_rt_data", ex_rt_data, m_rt);
            chk("ex_imm_ext", ex_imm_ext, m_imm);
        end
    endtask

    task automatic clear_ctl();
        {ctl_ex_regwr, ctl_memread, ctl_asel, ctl_bsel, ctl_aluop, ctl_wdstsel, ctl_mem_regwr,
         ctl_be, ctl_dmwr, ctl_wb_regwr, ctl_wcsel, ctl_wdstregsel, ctl_jmp, ctl_jmpr} = '0;
    endtask

    typedef struct {
        bit          rst, stall, vld;
        logic [31:0] instr;
        bit          mr, wdst, wreg, jmp, jmpr;
        logic [1:0]  wc;
        bit          hz, pcw, fl;
        bit          ev;
        logic [4:0]  ed;
        logic [1:0]  ewc;
        int          cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, s, v, input logic [31:0] ins, input bit mr, wdst, wreg,
                       jmp, jmpr, input logic [1:0] wc, input bit hz, pcw, fl, ev,
                       input logic [4:0] ed, input logic [1:0] ewc, input int cnt);
        vec_t e;
        e.rst = r; e.stall = s; e.vld = v; e.instr = ins; e.mr = mr; e.wdst = wdst;
        e.wreg = wreg; e.jmp = jmp; e.jmpr = jmpr; e.wc = wc; e.hz = hz; e.pcw = pcw;
        e.fl = fl; e.ev = ev; e.ed = ed; e.ewc = ewc; e.cnt = cnt;
        tbl.push_back(e);
    endtask

    task automatic drive_random(input bit force_rst);
        logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h0f, 6'h02, 6'h03, 6'h04, 6'h05,
                                6'h2b, 6'h28, 6'h29, 6'h08};
        logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd8, 5'd9};
        logic [5:0] op = ops[$urandom_range(10)];
        rst        = force_rst || ($urandom_range(39) == 0);
        ex_stall   = ($urandom_range(4) == 0);
        id_valid   = ($urandom_range(9) != 0);
        id_instr   = {op, regs[$urandom_range(3)], regs[$urandom_range(3)], 16'($urandom)};
        id_pc      = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
        {ctl_ex_regwr, ctl_asel, ctl_bsel, ctl_aluop, ctl_wdstsel, ctl_mem_regwr, ctl_be,
         ctl_dmwr, ctl_wb_regwr, ctl_wcsel, ctl_wdstregsel} = 18'($urandom);
        ctl_memread = (op == 6'h23) || ($urandom_range(7) == 0);
        ctl_jmp     = ($urandom_range(4) == 0);
        ctl_jmpr    = ($urandom_range(4) == 0);
    endtask

    initial begin
        logic [31:0] lw8, lw0, add8, add0, lui8, jal, jr8, sw8, addi;
        lw8  = enc_i(6'h23, 5'd1, 5'd8, 16'd0);
        lw0  = enc_i(6'h23, 5'd1, 5'd0, 16'd0);
        add8 = enc_r(5'd8, 5'd1, 5'd9);
        add0 = enc_r(5'd0, 5'd1, 5'd9);
        lui8 = enc_i(6'h0f, 5'd0, 5'd8, 16'h1234);
        jal  = {6'h03, 26'h10};
        jr8  = {6'h00, 5'd8, 15'd0, 6'h08};
        sw8  = enc_i(6'h2b, 5'd1, 5'd8, 16'd4);
        addi = enc_i(6'h08, 5'd1, 5'd8, 16'd1);

        //   rst stl vld instr mr wd wr jp jr wc   hz pcw fl  ev ed ewc cnt
        add(1, 0, 1, jal,  0, 0, 1, 1, 0, 2,   0, 1, 0,   0, 0, 0, 0);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 0);
        add(0, 0, 1, add8, 0, 1, 0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 1);
        add(0, 0, 1, add8, 0, 1, 0, 0, 0, 0,   0, 1, 0,   1, 9, 0, 1);
        add(0, 0, 1, lw0,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 0, 0, 1);
        add(0, 0, 1, add0, 0, 1, 0, 0, 0, 0,   0, 1, 0,   1, 9, 0, 1);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 1);
        add(0, 0, 1, lui8, 0, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 1);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 1);
        add(0, 1, 1, add8, 0, 1, 0, 0, 0, 0,   0, 0, 0,   1, 8, 0, 1);
        add(0, 1, 1, add8, 0, 1, 0, 1, 0, 0,   0, 0, 0,   1, 8, 0, 1);
        add(0, 1, 1, add8, 0, 1, 0, 0, 0, 0,   0, 0, 0,   1, 8, 0, 1);
        add(0, 0, 1, add8, 0, 1, 0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 2);
        add(0, 0, 1, add8, 0, 1, 0, 0, 0, 0,   0, 1, 0,   1, 9, 0, 2);
        add(0, 0, 1, jal,  0, 0, 1, 1, 0, 2,   0, 1, 1,   1, 31, 2, 2);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 2);
        add(0, 0, 1, jr8,  0, 0, 0, 0, 1, 0,   1, 0, 0,   0, 0, 0, 3);
        add(0, 0, 1, jr8,  0, 0, 0, 0, 1, 0,   0, 1, 1,   1, 0, 0, 3);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 3);
        add(0, 1, 1, add8, 0, 1, 0, 0, 0, 0,   0, 0, 0,   1, 8, 0, 3);
        add(1, 1, 1, add8, 0, 1, 0, 0, 0, 0,   0, 1, 0,   0, 0, 0, 0);
        add(0, 0, 1, add8, 0, 1, 0, 0, 0, 0,   0, 1, 0,   1, 9, 0, 0);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 0);
        add(1, 0, 1, add8, 0, 1, 0, 0, 0, 0,   0, 1, 0,   0, 0, 0, 0);
        add(0, 0, 1, add8, 0, 1, 0, 0, 0, 0,   0, 1, 0,   1, 9, 0, 0);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 0);
        add(0, 0, 0, add8, 0, 1, 0, 0, 0, 0,   0, 1, 0,   0, 0, 0, 0);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 0);
        add(0, 0, 1, sw8,  0, 0, 0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 1);
        add(0, 0, 1, sw8,  0, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 1);
        add(0, 0, 1, lw8,  1, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 1);
        add(0, 0, 1, addi, 0, 0, 0, 0, 0, 0,   0, 1, 0,   1, 8, 0, 1);

        rst = 1'b1; ex_stall = 1'b0; id_valid = 1'b0; id_instr = '0;
        id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm_ext = '0;
        clear_ctl();
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            clear_ctl();
            rst = tbl[i].rst; ex_stall = tbl[i].stall; id_valid = tbl[i].vld;
            id_instr = tbl[i].instr; id_pc = 32'h400 + 32'(i * 4);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm_ext = $urandom;
            ctl_memread = tbl[i].mr; ctl_wdstsel = tbl[i].wdst; ctl_wdstregsel = tbl[i].wreg;
            ctl_jmp = tbl[i].jmp; ctl_jmpr = tbl[i].jmpr; ctl_wcsel = tbl[i].wc;
            #2;
            chk($sformatf("row%0d hazard_stall", i), 32'(hazard_stall), 32'(tbl[i].hz));
            chk($sformatf("row%0d pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
            chk($sformatf("row%0d ifid_write", i), 32'(ifid_write), 32'(tbl[i].pcw));
            chk($sformatf("row%0d ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].fl));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
            if (tbl[i].ev) begin
                chk($sformatf("row%0d ex_dst", i), 32'(ex_dst), 32'(tbl[i].ed));
                chk($sformatf("row%0d ex_wcsel", i), 32'(ex_wcsel), 32'(tbl[i].ewc));
            end
        end

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drive_random(i == 0);
            #2;
            model_check();
        end

        // Counter ceiling: a self-dependent load bubbles every other cycle.
        @(negedge clk);
        clear_ctl();
        rst = 1'b1; ex_stall = 1'b0; id_valid = 1'b1;
        id_instr = enc_i(6'h23, 5'd8, 5'd8, 16'd0);
        ctl_memread = 1'b1;
        for (int i = 0; i < 2 * (int'(CNT_MAX) + 10); i++) begin
            @(negedge clk);
            rst = 1'b0;
            #2;
            model_check();
        end
        chk("cnt_saturated", 32'(stall_cnt), 32'(CNT_MAX));
        repeat (6) @(negedge clk);
        chk("cnt_stays_saturated", 32'(stall_cnt), 32'(CNT_MAX));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt_after_reset", 32'(stall_cnt), 32'd0);
        chk("valid_after_reset", 32'(ex_valid), 32'd0);
        chk("ctl_after_reset", 32'(dut_ctl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
